// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and a word-organised
// data memory (slave).
//
// Handshake: the master raises mem_req together with mem_addr, mem_be,
// mem_we and mem_wdata, and holds all of them stable until the cycle in
// which the slave returns mem_ack=1. That rising edge completes the beat,
// and mem_rdata is sampled on the same edge. An acknowledge may arrive in
// the same cycle as the request. mem_ack while mem_req=0 has no effect.
//
// Signals:
//   mem_req   master->slave  beat request
//   mem_we    master->slave  1 = write beat, 0 = read beat
//   mem_addr  master->slave  30-bit word address
//   mem_be    master->slave  byte enables, bit n = bits 8n+7:8n
//   mem_wdata master->slave  lane-aligned write data
//   mem_rdata slave->master  read data, valid with mem_ack
//   mem_ack   slave->master  beat complete
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a variable-latency,
// word-organised data memory. Byte/half/word accesses are steered onto
// little-endian byte lanes; an access that crosses a word boundary is split
// into two bus beats. Loads are sign- or zero-extended. The core is stalled
// while an access is in flight.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   rd_en, wr_en  load / store request from the control unit
//   size          00 word, 01 half, 10 byte, 11 reserved (illegal)
//   unsigned_ld   zero-extend byte/half loads
//   addr          byte address
//   wr_data       right-aligned store data
//   stall         hold PC and register-file write
//   done          one-cycle completion pulse
//   bus_err       one-cycle error pulse, coincident with done
//   rd_data       extended load result
//   state_dbg     current FSM state (IDLE=0, BEAT0=1, BEAT1=2, RESP=3)
//   bus           data-memory bus (master side)
//
// TIMEOUT: cycles a beat may wait for mem_ack before it is abandoned with
// bus_err; 0 disables the timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic        stall,
    output logic        done,
    output logic        bus_err,
    output logic [31:0] rd_data,
    output logic [1:0]  state_dbg,
    load_store_unit_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

    logic [1:0]  state;
    logic        is_load;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [2:0]  hi_be;       // lanes spilling into the next word
    logic [29:0] word_q;      // word address of the first beat
    logic [31:0] wdata_q;
    logic [63:0] asm_q;       // beat0 in 31:0, beat1 in 63:32
    logic [31:0] cnt;
    logic        err_q;
    logic [31:0] rd_data_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_out;

    logic        access;
    logic        illegal;
    logic [3:0]  mask;
    logic [6:0]  shifted;
    logic        in_beat;
    logic        timed_out;
    logic        go_beat1;
    logic        beat_fail;
    logic        finish;
    logic [63:0] asm_next;
    logic [63:0] aligned;
    logic [31:0] raw;
    logic [31:0] ld_result;

    assign access  = rd_en | wr_en;
    assign illegal = (size == 2'b11) | (rd_en & wr_en);

    always_comb begin
        case (size)
            2'b00:   mask = 4'b1111;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b0001;
        endcase
    end

    // 7 bits wide so lanes pushed past byte 3 are kept for the second beat.
    assign shifted = {3'b000, mask} << addr[1:0];

    assign in_beat   = (state == S_BEAT0) | (state == S_BEAT1);
    assign timed_out = TO_EN && (cnt == TO_LAST);
    // An acknowledge in the final allowed cycle wins over the timeout.
    assign go_beat1  = (state == S_BEAT0) & bus.mem_ack & (hi_be != 3'b000);
    assign beat_fail = in_beat & ~bus.mem_ack & timed_out;
    assign finish    = (in_beat & bus.mem_ack & ~go_beat1) | beat_fail;

    // Assembly register including the lanes arriving on this edge, so the
    // load result is ready when the final beat completes.
    always_comb begin
        asm_next = asm_q;
        for (int n = 0; n < 4; n++) begin
            if (bus.mem_ack && bus.mem_be[n]) begin
                if (state == S_BEAT1) begin
                    asm_next[32 + 8*n +: 8] = bus.mem_rdata[8*n +: 8];
                end else begin
                    asm_next[8*n +: 8] = bus.mem_rdata[8*n +: 8];
                end
            end
        end
    end

    assign aligned = asm_next >> {off_q, 3'b000};
    assign raw     = aligned[31:0];

    always_comb begin
        case (size_q)
            2'b00:   ld_result = raw;
            2'b01:   ld_result = {{16{~unsigned_q & raw[15]}}, raw[15:0]};
            default: ld_result = {{24{~unsigned_q & raw[7]}}, raw[7:0]};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            is_load    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            hi_be      <= 3'b000;
            word_q     <= 30'd0;
            wdata_q    <= 32'd0;
            asm_q      <= 64'd0;
            cnt        <= 32'd0;
            err_q      <= 1'b0;
            rd_data_q  <= 32'd0;
            we_q       <= 1'b0;
            addr_q     <= 30'd0;
            be_q       <= 4'b0000;
            wdata_out  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        is_load <= rd_en;
                        if (illegal) begin
                            state <= S_RESP;
                            err_q <= 1'b1;
                            if (rd_en) begin
                                rd_data_q <= 32'd0;
                            end
                        end else begin
                            state      <= S_BEAT0;
                            unsigned_q <= unsigned_ld;
                            size_q     <= size;
                            off_q      <= addr[1:0];
                            hi_be      <= shifted[6:4];
                            word_q     <= addr[31:2];
                            wdata_q    <= wr_data;
                            asm_q      <= 64'd0;
                            cnt        <= 32'd0;
                            we_q       <= wr_en;
                            addr_q     <= addr[31:2];
                            be_q       <= shifted[3:0];
                            wdata_out  <= wr_data << {addr[1:0], 3'b000};
                        end
                    end
                end
                S_BEAT0, S_BEAT1: begin
                    if (bus.mem_ack) begin
                        asm_q <= asm_next;
                    end
                    if (go_beat1) begin
                        state     <= S_BEAT1;
                        addr_q    <= word_q + 30'd1;    // wraps to word 0
                        be_q      <= {1'b0, hi_be};
                        // Only reached with off_q != 0, so the shift is 8..24.
                        wdata_out <= wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
                        cnt       <= 32'd0;
                    end else if (finish) begin
                        state <= S_RESP;
                        err_q <= beat_fail;
                        if (is_load) begin
                            rd_data_q <= beat_fail ? 32'd0 : ld_result;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    err_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset gates stall directly so it drops asynchronously with rst.
    assign stall     = rst & (((state == S_IDLE) & access) | in_beat);
    assign done      = (state == S_RESP);
    assign bus_err   = err_q;
    assign rd_data   = rd_data_q;
    assign state_dbg = state;

    assign bus.mem_req   = in_beat;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_out;
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized accesses
// against a byte-addressed reference memory, with a scoreboard of expected
// responses and expected bus beats.
module tb_load_store_unit;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic        stall;
    logic        done;
    logic        bus_err;
    logic [31:0] rd_data;
    logic [1:0]  state_dbg;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .addr        (addr),
        .wr_data     (wr_data),
        .stall       (stall),
        .done        (done),
        .bus_err     (bus_err),
        .rd_data     (rd_data),
        .state_dbg   (state_dbg),
        .bus         (bus)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [29:0] wa;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          wt;      // cycles before the memory acknowledges
    } beat_t;

    logic [32:0] exp_q[$];    // {bus_err, rd_data}
    beat_t       exp_beat_q[$];

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] model_rd = 32'd0;
    logic [7:0]  ref_mem[logic [31:0]];
    logic [31:0] bus_mem[logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_note(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return ({wa, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [29:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word(a[31:2]);
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic preload(input logic [29:0] wa, input logic [31:0] word);
        bus_mem[wa] = word;
        for (int i = 0; i < 4; i++) ref_mem[{wa, 2'(i)}] = word[8*i +: 8];
    endtask

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz, input logic u);
        case (sz)
            2'b00:   return v;
            2'b01:   return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        endcase
    endfunction

    // ---------------- memory responder / beat monitor ----------------
    beat_t cur;
    logic  cur_bogus   = 1'b0;
    logic  resp_active = 1'b0;
    logic  resp_acked  = 1'b0;
    int    resp_cnt    = 0;

    initial begin
        logic [31:0] wv;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                resp_active = 1'b0;
                resp_acked  = 1'b0;
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req) begin
                if (!resp_active || resp_acked) begin
                    if (exp_beat_q.size() == 0) begin
                        $display("FAIL unexpected_beat: got word %0h expected no beat", bus.mem_addr);
                        n_total++;
                        cur_bogus = 1'b1;
                        cur.wt    = 0;
                    end else begin
                        cur       = exp_beat_q.pop_front();
                        cur_bogus = 1'b0;
                    end
                    resp_active = 1'b1;
                    resp_cnt    = 0;
                end
                if (!cur_bogus) begin
                    check("beat_addr", 32'(bus.mem_addr), 32'(cur.wa));
                    check("beat_be", 32'(bus.mem_be), 32'(cur.be));
                    check("beat_we", 32'(bus.mem_we), 32'(cur.we));
                    check("beat_wdata", bus.mem_wdata, cur.wdata);
                end
                if (resp_cnt == cur.wt) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus_rd(bus.mem_addr);
                    if (bus.mem_we) begin
                        wv = bus_rd(bus.mem_addr);
                        for (int j = 0; j < 4; j++)
                            if (bus.mem_be[j]) wv[8*j +: 8] = bus.mem_wdata[8*j +: 8];
                        bus_mem[bus.mem_addr] = wv;
                    end
                    resp_acked = 1'b1;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    resp_acked    = 1'b0;
                end
                resp_cnt++;
            end else begin
                if (resp_active && !resp_acked) check("timeout_req_cycles", 32'(resp_cnt), 32'(TO));
                resp_active   = 1'b0;
                resp_acked    = 1'b0;
                bus.mem_ack   = 1'($urandom_range(0, 1));   // stray acks must be ignored
                bus.mem_rdata = $urandom;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (exp_q.size() == 0) begin
                    fail_note("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("bus_err", 32'(bus_err), 32'(e[32]));
                    check("rd_data", rd_data, e[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the rising edge
    // that leaves RESP, with the request withdrawn.
    task automatic do_access(input logic r, input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd, input int w0, input int w1);
        int          n;
        int          o;
        int          idx;
        int          k;
        int          exp_stall;
        int          st;
        logic        got;
        logic        ok0;
        logic        ok1;
        logic        err;
        logic        two;
        logic [29:0] wa0;
        logic [31:0] b;
        logic [31:0] val;
        logic [3:0]  bes[2];
        logic [31:0] wds[2];

        n   = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        o   = int'(a[1:0]);
        wa0 = a[31:2];
        for (int kk = 0; kk < 2; kk++) begin
            bes[kk] = 4'b0000;
            wds[kk] = 32'd0;
            for (int j = 0; j < 4; j++) begin
                idx = 4*kk + j - o;
                if (idx >= 0 && idx < 4) wds[kk][8*j +: 8] = wd[8*idx +: 8];
            end
        end
        for (int i = 0; i < n; i++) begin
            b = a + 32'(i);
            k = (b[31:2] == wa0) ? 0 : 1;
            bes[k][b[1:0]] = 1'b1;
        end
        two = (bes[1] != 4'b0000);

        if (sz == 2'b11 || (r && w)) begin
            err = 1'b1;
            exp_stall = 1;
            if (r) model_rd = 32'd0;
        end else begin
            ok0 = (w0 < TO);
            ok1 = two ? (w1 < TO) : 1'b1;
            exp_beat_q.push_back('{wa: wa0, be: bes[0], we: w, wdata: wds[0], wt: w0});
            exp_stall = 1 + (ok0 ? w0 + 1 : TO);
            if (two && ok0) begin
                exp_beat_q.push_back('{wa: wa0 + 30'd1, be: bes[1], we: w, wdata: wds[1], wt: w1});
                exp_stall += ok1 ? w1 + 1 : TO;
            end
            err = !ok0 || (two && !ok1);
            val = 32'd0;
            for (int i = 0; i < n; i++) begin
                b = a + 32'(i);
                k = (b[31:2] == wa0) ? 0 : 1;
                if (w && ((k == 0) ? ok0 : (ok0 && ok1))) ref_mem[b] = wd[8*i +: 8];
                val[8*i +: 8] = ref_byte(b);
            end
            if (r) model_rd = err ? 32'd0 : extend(val, sz, u);
        end
        exp_q.push_back({err, model_rd});

        rd_en = r; wr_en = w; size = sz; unsigned_ld = u; addr = a; wr_data = wd;
        st = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("stall_at_done", 32'(stall), 32'd0);
            end else if (stall) begin
                st++;
            end
        end
        if (!got) fail_note("done_never_seen");
        else check("stall_cycles", 32'(st), 32'(exp_stall));
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    function automatic int pick_wait();
        int v;
        v = $urandom_range(0, 99);
        if (v < 80) return $urandom_range(0, 3);
        if (v < 90) return TO - 1;
        if (v < 95) return TO;
        return 255;
    endfunction

    initial begin
        logic        got;
        logic        r;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          op;

        // Reset state, with a request present to show stall stays low.
        rd_en = 1'b1;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed scenarios.
        preload(30'h40, 32'h800000FF);
        do_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 0, 0);            // LW zero-wait
        preload(30'h40, 32'h80AABBCC);
        do_access(1, 0, 2'b10, 0, 32'h103, 32'h0, 0, 0);            // LB
        do_access(1, 0, 2'b10, 1, 32'h103, 32'h0, 0, 0);            // LBU
        do_access(0, 1, 2'b01, 0, 32'h103, 32'h0000BEEF, 0, 0);     // SH split
        preload(30'h40, 32'h22115566);
        preload(30'h41, 32'h77884433);
        do_access(1, 0, 2'b00, 0, 32'h102, 32'h0, 3, 3);            // LW split, late acks
        do_access(1, 0, 2'b00, 0, 32'h200, 32'h0, 255, 0);          // LW timeout
        do_access(1, 0, 2'b11, 0, 32'h200, 32'h0, 0, 0);            // reserved size
        do_access(1, 1, 2'b00, 0, 32'h200, 32'h0, 0, 0);            // load+store
        do_access(0, 1, 2'b00, 0, 32'h302, 32'hCAFEF00D, 1, 255);   // beat1 times out

        // Reset during the second beat of a split load.
        preload(30'h50, 32'h11223344);
        exp_beat_q.push_back('{wa: 30'h50, be: 4'b1100, we: 1'b0, wdata: 32'h0, wt: 0});
        exp_beat_q.push_back('{wa: 30'h51, be: 4'b0011, we: 1'b0, wdata: 32'h0, wt: 255});
        rd_en = 1'b1; wr_en = 1'b0; size = 2'b00; addr = 32'h142; wr_data = 32'h0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (state_dbg == 2'd2) got = 1'b1;
        end
        if (!got) fail_note("beat1_not_reached");
        #2;
        rst = 1'b0;
        resp_active = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_mid_rd_data", rd_data, 32'd0);
        rd_en = 1'b0;
        model_rd = 32'd0;
        exp_beat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Top-of-memory wrap.
        do_access(1, 0, 2'b00, 0, 32'hFFFFFFFC, 32'h0, 0, 0);
        do_access(1, 0, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 1, 2);

        // Randomized accesses.
        for (int t = 0; t < 300; t++) begin
            op = $urandom_range(0, 19);
            r  = (op == 0) || (op < 10);
            w  = (op == 0) || (op >= 10);
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else a = 32'($urandom_range(0, 63));
            do_access(r, w, sz, 1'($urandom_range(0, 1)), a, $urandom, pick_wait(), pick_wait());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("resp_q_drained", 32'(exp_q.size()), 32'd0);
        check("beat_q_drained", 32'(exp_beat_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #2000000;
        fail_note("watchdog_expired");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the single-cycle core's execute stage (ALU address, register read port 2, control-unit memory strobes) and a word-organised data memory with a variable-latency req/ack handshake. It handles byte/half/word accesses with little-endian lane steering and sign/zero extension. Accesses that cross a word boundary are split into two bus beats. While an access is in flight it stalls the core, holding the PC and the register-file write.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles per beat without mem_ack before a bus error is raised; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  load request (control unit d_mem_rd_en)
- wr_en  in  1  store request (control unit d_mem_wr_en)
- size  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved
- unsigned_ld  in  1  zero-extend loads (LBU/LHU); ignored for word and stores
- addr  in  32  byte address (ALU output)
- wr_data  in  32  store data (register read port 2), right-aligned
- stall  out  1  hold PC and register-file write this cycle
- done  out  1  one-cycle pulse: access complete
- bus_err  out  1  one-cycle pulse with done: access failed
- rd_data  out  32  extended load result
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  30  bus word address
- mem_be  out  4  byte enables; bit n = byte lane n (bits 8n+7:8n)
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  read data, sampled when mem_ack=1
- mem_ack  in  1  beat complete

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- An access is present when rd_en or wr_en is 1. The core holds all inputs stable while stall=1.
- IDLE:
  - On a legal access, latch the request, compute lanes and go to BEAT0.
  - Illegal requests are size=11, or rd_en and wr_en both 1. They go directly to RESP with bus_err and issue no bus traffic.
- Lanes: off=addr[1:0]; mask = 0001 (byte), 0011 (half), 1111 (word). Shifted mask = mask<<off, 7 bits wide.
  - BEAT0: mem_addr=addr[31:2], mem_be=shifted[3:0], mem_wdata=wr_data<<(8*off).
  - BEAT1 is entered only if shifted[6:4]≠0. It uses mem_addr=addr[31:2]+1 (wraps modulo 2^30 to 0), mem_be={0,shifted[6:4]}, mem_wdata=wr_data>>(8*(4-off)).
- Beat handshake:
  - mem_req=1 with mem_addr/mem_be/mem_we/mem_wdata stable from beat entry until the cycle mem_ack=1 (same-cycle ack allowed).
  - The beat ends on that edge. mem_req is 0 the following cycle unless the next beat starts.
  - mem_ack while mem_req=0 is ignored.
- Loads: enabled lanes of each beat are captured into a 64-bit assembly register, beat0 in bits 31:0 and beat1 in bits 63:32. The result is assembly>>(8*off), truncated to size. It is extended from bit 7 (byte) or bit 15 (half) unless unsigned_ld.
- Timeout:
  - A per-beat counter clears on beat entry. When it reaches TIMEOUT without ack, mem_req drops and the FSM goes to RESP with bus_err.
  - If a BEAT1 times out, the BEAT0 store already committed stays committed.
- RESP:
  - done=1 and stall=0, so the core advances on this edge. Next state is IDLE.
  - rd_data updates on RESP entry for loads: the result, or 0 on bus_err. Stores leave it unchanged.
- stall = (IDLE and access present) or BEAT0 or BEAT1. It is 0 in RESP and during reset.

## Timing
- Reset (rst=0, asynchronous): state IDLE and all outputs 0, including rd_data. Any in-flight beat is abandoned and mem_req drops immediately with no completion.
- Zero-wait aligned access: cycle 0 IDLE (stall=1), cycle 1 BEAT0 (req, ack), cycle 2 RESP (done). Stall lasts 2 cycles.
- General case: stall cycles = 1 + sum over beats of (wait+1), where wait is the number of cycles before mem_ack. done comes the cycle after the last beat.
- After RESP, IDLE samples the next instruction's request one cycle later. There are no back-to-back bus beats across instructions.

## Test plan
- LW addr 0x100, mem_rdata 0x800000FF, zero-wait → mem_addr 0x40, be 1111, done in cycle 2, rd_data 0x800000FF, stall high for 2 cycles.
- LB addr 0x103, mem_rdata 0x80AABBCC → be 1000, rd_data 0xFFFFFF80. Same with unsigned_ld=1 → 0x00000080.
- SH addr 0x103, wr_data 0x0000BEEF → beat0 word 0x40, be 1000, wdata 0xEF000000. Beat1 word 0x41, be 0001, wdata 0x000000BE. mem_we=1 on both beats.
- LW addr 0x102, each beat acked 3 cycles late, words 0x2211xxxx and 0xxxxx4433 → rd_data 0x44332211, stall 9 cycles, single done pulse.
- TIMEOUT=8, no ack on LW → mem_req high exactly 8 cycles, then done=bus_err=1 for one cycle, rd_data 0. Also: size=11 → bus_err with mem_req never asserted.
- rst pulled low during BEAT1 → mem_req and stall drop immediately. After release, LW addr 0xFFFFFFFC completes normally at mem_addr 0x3FFFFFFF, and a half load at 0xFFFFFFFF wraps beat1 to mem_addr 0.
